// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that reuses one full-adder cell over WIDTH cycles, LSB first
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic             w_sum, w_cout, w_load, w_last;
    full_adder_cell u_cell (
        .i_a   (r_a_sh[0]),
        .i_b   (r_b_sh[0]),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );
    assign w_load = (r_state != RUN) && i_start;
    assign w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    always_comb begin
        w_next = r_state;
        w_next = w_load ? RUN : (r_state == DONE) ? IDLE : w_last ? DONE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_a_sh  <= i_a;
                r_b_sh  <= i_b;
                r_carry <= i_cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_s_sh  <= {w_sum, r_s_sh[WIDTH-1:1]};
                r_carry <= w_cout;
                r_a_sh  <= r_a_sh >> 1;
                r_b_sh  <= r_b_sh >> 1;
                r_cnt   <= r_cnt + 1'b1;
            end
            // result registers only move on the final bit step
            if (w_last) begin
                r_sum  <= {w_sum, r_s_sh[WIDTH-1:1]};
                r_cout <= w_cout;
            end
        end
    end
    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst, i_start, i_cin;
    logic [7:0] i_a, i_b;
    logic       o_busy, o_done, o_cout;
    logic [7:0] o_sum;
    int         n_checks = 0;
    int         n_errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_cin  (i_cin),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_sum  (o_sum),
        .o_cout (o_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] es, input logic ec);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        i_a = a; i_b = b; i_cin = c; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        i_a = ~a; i_b = ~b; i_cin = ~c;
        while (!o_done && n < 20) begin
            n++;
            if (o_busy) nb++;
            tick;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_busy"}, nb, 8);
        check({tag, "_sum"}, o_sum, es);
        check({tag, "_cout"}, o_cout, ec);
        check({tag, "_busy_in_done"}, o_busy, 0);
        tick;
        check({tag, "_done_1cyc"}, o_done, 0);
        check({tag, "_hold"}, {o_cout, o_sum}, {ec, es});
    endtask

    initial begin
        int nd;
        int t;
        int td[2];
        logic [8:0] r[2];
        logic hold_bad;
        rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sum", o_sum, 0);
        check("rst_cout", o_cout, 0);

        run_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        i_a = 8'h10; i_b = 8'h20; i_cin = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        tick;
        tick;
        i_a = 8'h01; i_b = 8'h02; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            if (o_done) begin
                nd++;
                check("ign_sum", o_sum, 8'h30);
                check("ign_cout", o_cout, 0);
            end
            tick;
        end
        check("ign_ndone", nd, 1);

        i_a = 8'hAA; i_b = 8'h55; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        tick;
        tick;
        tick;
        check("mid_busy_pre", o_busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_busy", o_busy, 0);
        check("mid_done", o_done, 0);
        check("mid_sum", o_sum, 0);
        check("mid_cout", o_cout, 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (o_done) nd++;
            tick;
        end
        check("mid_ndone", nd, 0);

        i_a = 8'h01; i_b = 8'h01; i_cin = 1'b0; i_start = 1'b1;
        tick;
        i_a = 8'h80; i_b = 8'h80;
        nd = 0;
        t = 1;
        hold_bad = 1'b0;
        td[0] = 0; td[1] = 0; r[0] = '0; r[1] = '0;
        while (nd < 2 && t < 40) begin
            if (o_done) begin
                td[nd] = t;
                r[nd] = {o_cout, o_sum};
                nd++;
                if (nd == 2) i_start = 1'b0;
            end else if (nd == 1 && {o_cout, o_sum} !== 9'h002) begin
                hold_bad = 1'b1;
            end
            if (nd < 2) tick;
            t++;
        end
        check("b2b_ndone", nd, 2);
        check("b2b_gap", td[1] - td[0], 9);
        check("b2b_r0", r[0], 9'h002);
        check("b2b_r1", r[1], 9'h100);
        check("b2b_hold", hold_bad, 0);
        tick;
        check("b2b_idle_busy", o_busy, 0);
        check("b2b_idle_done", o_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that time-shares one 1-bit full adder cell (inputs a, b, cin; outputs sum, cout) across all bits of two WIDTH-bit operands. It accepts an operand pair on a start pulse, sequences the cell LSB-first over WIDTH cycles, and holds a registered result with a one-cycle done strobe. It serves area-constrained datapaths where a ripple-carry adder is too large.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only when the block is ready.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle strobe: sum/cout have just been updated.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered final carry-out, held with sum.

## Operation
- Exactly one full adder cell instance. No other adder logic in the design.
- Internal registers: a_sh and b_sh (WIDTH-bit shift-right registers), carry (1 bit), s_sh (WIDTH-bit shift-right accumulator), and cnt (bit counter of width clog2(WIDTH)).
- Cell hookup: a = a_sh[0], b = b_sh[0], cin = carry.
- FSM states are IDLE, RUN and DONE. Ready = IDLE or DONE.
- IDLE, or DONE, with start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0. Go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, every edge:
  - s_sh <= {cell.sum, s_sh[WIDTH-1:1]}; carry <= cell.cout.
  - a_sh and b_sh shift right by 1; cnt <= cnt+1.
- RUN with cnt==WIDTH-1: perform the bit step above, and also load sum <= {cell.sum, s_sh[WIDTH-1:1]} and cout <= cell.cout. Go to DONE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - sum and cout change only on the RUN->DONE edge or on reset.
- start while in RUN is ignored; the operation in progress is unaffected.
- Arithmetic: {cout,sum} = a + b + cin, exact over WIDTH+1 bits with no truncation.

## Timing
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, carry=0, shift registers=0. Reset has priority over every other event, including mid-RUN.
  - Reset mid-RUN aborts the operation.
  - Reset mid-RUN never produces done.
  - Reset mid-RUN clears any previously held sum/cout.
- Edge numbering: start accepted at edge E0.
  - busy is high from E0 through E_WIDTH.
  - done is high for exactly the cycle between E_WIDTH and E_WIDTH+1.
  - Latency from accept to done is WIDTH+1 edges.
- Back-to-back: start held high during DONE is accepted at E_WIDTH+1. busy goes high again with no idle gap. Throughput is one operation per WIDTH+1 cycles.
- Operand inputs a, b and cin are don't-care except at the accepting edge. Changes during RUN have no effect.
- start is level-sampled. If start is held high continuously, an operation is accepted every WIDTH+1 cycles.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy high 8 cycles, then done for 1 cycle, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Assert start with a=0x01, b=0x02 in the 3rd RUN cycle of an operation with a=0x10, b=0x20 -> the second start is ignored; result sum=0x30; done pulses exactly once.
- rst=1 in RUN cycle 4 of a=0xAA, b=0x55 -> next cycle: busy=0, done=0, sum=0x00, cout=0. No done pulse follows.
- start held high, operand pairs (0x01,0x01) then (0x80,0x80) -> done pulses 9 cycles apart. Results are sum=0x02 with cout=0, then sum=0x00 with cout=1. The first result holds until the second done.
